// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N valid/ready requesters.
// Grants one owner for up to BURST words and forwards the source index with the data.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_we,
  output logic [W-1:0]         fifo_wd,
  output logic [$clog2(N)-1:0] fifo_wid,
  output logic [N-1:0]         grant,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   nxt;
  logic            any_vld, own_vld, xfer, last, rel;

  // First valid index after p (wrapping), with p itself considered last.
  function automatic logic [IW-1:0] pick(input logic [IW-1:0] p, input logic [N-1:0] v);
    logic [IW-1:0] r;
    logic [IW-1:0] idx;
    int            s;
    r = p;
    for (int k = N; k >= 1; k--) begin
      s = int'(p) + k;
      if (s >= N) s = s - N;
      idx = IW'(s);
      if (v[idx]) r = idx;
    end
    return r;
  endfunction

  // While busy, ptr_q holds the current owner's index.
  always_comb begin
    busy      = (state_q == GRANT);
    grant     = busy ? (N'(1) << ptr_q) : '0;
    own_vld   = req_valid[ptr_q];
    xfer      = busy & own_vld & ~fifo_full & ~rst;
    req_ready = grant & {N{~fifo_full & ~rst}};
    fifo_we   = xfer;
    fifo_wd   = busy ? req_data[int'(ptr_q)*W +: W] : '0;
    fifo_wid  = busy ? ptr_q : '0;
    any_vld   = |req_valid;
    nxt       = pick(ptr_q, req_valid);
    last      = (cnt_q == CW'(BURST - 1));
    rel       = (xfer & last) | ~own_vld;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d = GRANT;
          ptr_d   = nxt;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = cnt_q + 1'b1;
        // A release hands over directly to the next requester, no idle gap.
        if (rel) begin
          cnt_d = '0;
          if (any_vld) ptr_d = nxt;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a fifo_dc instance between N requesters.
- Each requester presents a valid/ready stream; the arbiter grants one owner at a time for a burst of up to BURST words.
- The arbiter drives the FIFO we/wd directly and stalls on the FIFO full flag.
- Sits in the FIFO write-clock domain and forwards the source index alongside the data.

Parameters:
- N, 4, number of requesters (2..16)
- W, 4, data width; matches the FIFO W
- BURST, 4, maximum consecutive words per grant (1..256)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  N  per-requester data valid
- req_data  in  N*W  requester i data in bits [i*W+W-1 : i*W]
- req_ready  out  N  per-requester accept
- fifo_full  in  1  FIFO full flag
- fifo_we  out  1  FIFO write enable
- fifo_wd  out  W  FIFO write data
- fifo_wid  out  clog2(N)  index of the source of fifo_wd
- grant  out  N  one-hot current owner, or all zero
- busy  out  1  high while in state GRANT

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, grant=0, cnt=0.
  - Priority pointer ptr=N-1, so requester 0 wins first.
  - Outputs: fifo_we=0, req_ready=0, busy=0, fifo_wid=0, fifo_wd=0.
  - rst has priority over all other events; an in-progress burst is aborted with no write.
- Combinational datapath (zero latency from grant):
  - req_ready[i] = grant[i] & ~fifo_full.
  - xfer = busy & req_valid[own] & ~fifo_full, where own is the index of grant.
  - fifo_we = xfer.
  - fifo_wd = req_data slice of own; fifo_wid = own (both valid whenever busy).
  - fifo_we is never high while fifo_full=1, so the FIFO cannot overflow.
- Arbitration function pick(p):
  - Returns the first index i with req_valid[i]=1, scanning p+1, p+2, ... mod N.
  - Index p itself is checked last.
- State IDLE:
  - If any req_valid=1: grant <= onehot(pick(ptr)), ptr <= pick(ptr), cnt <= 0, state <= GRANT.
  - The first transfer is possible one cycle after the request is seen.
- State GRANT, each cycle:
  - xfer=1: cnt <= cnt+1.
  - release = (xfer & cnt==BURST-1) | ~req_valid[own].
  - release=1 and some req_valid=1 (the current owner included, scanned last): grant <= onehot(pick(own)), ptr <= that index, cnt <= 0, stay in GRANT. There is no idle cycle between owners.
  - release=1 and no req_valid=1: grant <= 0, state <= IDLE.
  - fifo_full=1 with owner valid: no transfer, cnt frozen, grant held indefinitely. No timeout.
- Counter: cnt is clog2(BURST)+1 bits and never exceeds BURST-1. With BURST=1, every transfer releases.
- Requester obligations: req_data must be stable while req_valid=1 and req_ready=0. Valid may drop at any time; the arbiter treats a drop as a release.
- Simultaneous events:
  - A new request arriving in the owner's last-word cycle competes in that cycle's pick.
  - fifo_full rising in the last-word cycle blocks the transfer, so no release occurs.

Test Plan:
- N=4, W=4, BURST=2, only req 1 valid with words 1,2,4,8 back-to-back -> grant=0010 from the cycle after valid; fifo_we high for 4 consecutive cycles; fifo_wd=1,2,4,8; fifo_wid=1; then IDLE, busy=0.
- All four valid continuously after reset, each source sending its index as data -> fifo_wid sequence 0,0,1,1,2,2,3,3,0,0; fifo_we continuously high after the first grant cycle.
- fifo_full=1 for 3 cycles after the first word of a burst from req 2 -> fifo_we=0 and req_ready=0000 for 3 cycles; grant stays 0100; the second word is written the cycle fifo_full falls; then release.
- Req 0 drops valid after 1 word while req 3 is valid -> next cycle grant=1000, fifo_wid=3; req 0's cnt does not carry over (req 3 gets a full 2-word burst).
- rst=1 mid-burst of req 2 -> next cycle grant=0, fifo_we=0, busy=0; after rst=0 with req 2 and req 0 both valid, req 0 is granted first.
- Only req 3 valid immediately after reset -> grant=1000 the next cycle; with BURST=1 and req 3 held valid, req 3 is regranted every cycle and fifo_we stays continuously high.
